// File: rtl/pull_fifo_pkg.sv
// Shared constants and helpers for the pull_fifo elastic buffer.
package pull_fifo_pkg;

  localparam int stat_w        = 32;
  localparam int default_depth = 4;

  // Pointer width for a buffer of d entries (at least one bit).
  function automatic int ptr_width(input int d);
    int w;
    w = 32'sd0;
    for (int i = 0; i < 32; i++) begin
      if ((32'sd1 << w) < d) begin
        w = w + 32'sd1;
      end
    end
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

endpackage

// File: rtl/pull_fifo_mem.sv
// Storage array for pull_fifo: one synchronous write port, one asynchronous read port.
module pull_fifo_mem
  import pull_fifo_pkg::*;
#(
  parameter int data_width = 32,
  parameter int depth      = default_depth,
  parameter int aw         = ptr_width(depth)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [aw-1:0]         waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [aw-1:0]         raddr,
  output logic [data_width-1:0] rdata
);

  logic [data_width-1:0] mem_r [depth];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/pull_fifo.sv
// Elastic req/ack buffer between an upstream producer and a downstream consumer.
// Optional statistics counters are built when PULL_FIFO_STATS_EN is defined.
module pull_fifo
  import pull_fifo_pkg::*;
#(
  parameter int data_width = 32,
  parameter int depth      = default_depth
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         up_req,
  input  logic                         up_ack,
  input  logic [data_width-1:0]        up_din,
  input  logic                         dn_req,
  output logic                         dn_ack,
  output logic [data_width-1:0]        dn_dout,
  output logic [ptr_width(depth):0]    occupancy,
  output logic                         overflow,
  output logic [stat_w-1:0]            stat_in,
  output logic [stat_w-1:0]            stat_out,
  output logic [ptr_width(depth):0]    stat_peak
);

  localparam int pw = ptr_width(depth);
  localparam int cw = pw + 1;
  localparam logic [cw-1:0] full_lvl = cw'(depth);
  localparam logic [cw-1:0] req_lvl  = cw'(depth - 2);

  logic [pw-1:0]         wp_r, rp_r;
  logic [cw-1:0]         cnt_r, cnt_nxt_s;
  logic                  push_s, pop_s, full_s;
  logic [data_width-1:0] rd_data_s;

  pull_fifo_mem #(.data_width(data_width), .depth(depth), .aw(pw)) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wp_r),
    .wdata (up_din),
    .raddr (rp_r),
    .rdata (rd_data_s)
  );

  // Push/pop decisions and next occupancy.
  always_comb begin
    full_s    = (cnt_r == full_lvl);
    push_s    = up_ack && !full_s;
    pop_s     = dn_req && !dn_ack && (cnt_r != {cw{1'b0}});
    cnt_nxt_s = cnt_r;
    if (push_s && !pop_s) begin
      cnt_nxt_s = cnt_r + cw'(1);
    end else if (pop_s && !push_s) begin
      cnt_nxt_s = cnt_r - cw'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Pointers, occupancy and all handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_r     <= {pw{1'b0}};
      rp_r     <= {pw{1'b0}};
      cnt_r    <= {cw{1'b0}};
      up_req   <= 1'b0;
      dn_ack   <= 1'b0;
      dn_dout  <= {data_width{1'b0}};
      overflow <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      // Stop requesting one entry early so a single late ack still fits.
      up_req <= (cnt_nxt_s <= req_lvl);
      dn_ack <= pop_s;
      if (push_s) begin
        wp_r <= wp_r + pw'(1);
      end
      if (pop_s) begin
        rp_r    <= rp_r + pw'(1);
        dn_dout <= rd_data_s;
      end
      if (up_ack && full_s) begin
        overflow <= 1'b1;
      end
    end
  end

  assign occupancy = cnt_r;

`ifdef PULL_FIFO_STATS_EN
  logic [stat_w-1:0] stat_in_r, stat_out_r;
  logic [cw-1:0]     stat_peak_r;

  // Throughput counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_in_r   <= {stat_w{1'b0}};
      stat_out_r  <= {stat_w{1'b0}};
      stat_peak_r <= {cw{1'b0}};
    end else begin
      if (push_s) begin
        stat_in_r <= stat_in_r + stat_w'(1);
      end
      if (pop_s) begin
        stat_out_r <= stat_out_r + stat_w'(1);
      end
      if (cnt_nxt_s > stat_peak_r) begin
        stat_peak_r <= cnt_nxt_s;
      end
    end
  end

  assign stat_in   = stat_in_r;
  assign stat_out  = stat_out_r;
  assign stat_peak = stat_peak_r;
`else
  assign stat_in   = {stat_w{1'b0}};
  assign stat_out  = {stat_w{1'b0}};
  assign stat_peak = {cw{1'b0}};
`endif

endmodule

// File: doc/pull_fifo.md
# pull_fifo

Elastic buffer that sits directly downstream of the `arf` output port (`dout_req_N`/`dout_ack_N`/`dout_N`) and upstream of a `consumer`. Toward `arf` it behaves as a consumer: it pulls words with a req/ack handshake. Toward the consumer it behaves as a producer: it serves buffered words with the same handshake. It decouples consumer stalls (`fail_rate`) from the dataflow graph and reports occupancy and overflow for throughput studies.

## Interface
Parameters:
- `data_width`, 32, word width.
- `depth`, 4, number of storage entries; power of two, minimum 2.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, asynchronous, active-low (asserted when 0).
- `up_req`  out  1  pull request to upstream `dout_req`.
- `up_ack`  in  1  one-cycle upstream ack; data valid in that cycle.
- `up_din`  in  data_width  upstream data.
- `dn_req`  in  1  downstream consumer request.
- `dn_ack`  out  1  one-cycle ack to consumer.
- `dn_dout`  out  data_width  word delivered with `dn_ack`.
- `occupancy`  out  $clog2(depth)+1  entries currently stored.
- `overflow`  out  1  sticky error: `up_ack` arrived while full.
- `stat_in`  out  32  words accepted (stats build only).
- `stat_out`  out  32  words delivered (stats build only).
- `stat_peak`  out  $clog2(depth)+1  maximum occupancy seen (stats build only).

## Operation
- Storage is a circular buffer with write pointer `wp`, read pointer `rp`, and occupancy counter `cnt`. Pointers are $clog2(depth) bits wide and wrap modulo `depth`.
- Push: at any edge with `up_ack`=1 and `cnt`<depth, write `up_din` at `wp`, then increment `wp`.
- Push while full: drop the word and set `overflow`. `overflow` clears only on reset.
- Pop: at any edge with `dn_req`=1, `dn_ack`=0 and `cnt`>0:
  - register `dn_ack`<=1;
  - register `dn_dout`<=mem[`rp`];
  - increment `rp`.
- Otherwise `dn_ack`<=0, so `dn_ack` is always a single-cycle pulse. `dn_dout` holds its last value between pulses.
- Simultaneous push and pop in one edge: both occur and `cnt` is unchanged. A pop never returns the word being pushed in that same edge; that word becomes eligible on the next edge.
- Empty: no `dn_ack`, regardless of `dn_req`.
- `up_req` is a register. Its next value is 1 iff next-state `cnt` ≤ depth-2. This leaves room for the single in-flight ack an upstream operator can issue after `up_req` falls, so a compliant upstream never causes an overflow.
- `occupancy` = `cnt`.
- Reset values: `up_req`=0, `dn_ack`=0, `dn_dout`=0, `occupancy`=0, `overflow`=0, all stat outputs=0, pointers=0. Memory contents are not reset.
- Reset mid-operation: buffered words are discarded. An `up_ack` during reset is ignored. `up_req` rises on the first edge after release.

## Timing
- Fall-through latency: a word pushed at edge k can be acked downstream at edge k+1 at the earliest (`dn_ack` and `dn_dout` are visible after k+1).
- Downstream peak rate is one word per 2 cycles, matching `producer`. Upstream accepts one word per cycle.
- `up_req` lags the occupancy change by one edge.
- Every output is a register; no combinational path exists from input to output.

## Configuration
- `PULL_FIFO_STATS_EN` defined:
  - `stat_in` increments on each accepted push.
  - `stat_out` increments on each pop.
  - Both counters wrap at 2^32.
  - `stat_peak` tracks the maximum `cnt`.
- `PULL_FIFO_STATS_EN` undefined: the three stat ports remain present and are tied to 0, and no counter logic is built.

## Structure
- Package `pull_fifo_pkg` holds:
  - the pointer/count width function (clog2);
  - the stat counter width constant (32);
  - the default `depth`.
- Sub-module `pull_fifo_mem`: a depth×data_width register array with one synchronous write port and one asynchronous read port, indexed by `wp`/`rp`. The control logic and the pointer/count logic live in `pull_fifo`.

## Test plan
- Reset release, then upstream acks data 0,1,2 on consecutive cycles with `dn_req`=0 → `occupancy` reads 3, `up_req` falls after the third push, no `overflow`.
- `dn_req` held at 1 after the test above → `dn_ack` pulses on every other cycle with `dn_dout` 0,1,2 in order, then `occupancy`=0.
- depth=4, upstream `producer` with fail_rate 0 and consumer with fail_rate 50, 5000 words → consumer receives 0..4999 in order, `overflow`=0, `stat_in`=`stat_out`=5000 (stats build).
- Force `up_ack` while `cnt`=4 (protocol violation) → word dropped, `overflow`=1 and held until `rst`=0.
- Push and pop in the same edge at `cnt`=2 → `cnt` stays 2, popped value is the older head, not the new word.
- Assert `rst`=0 asynchronously mid-stream with `cnt`=3 → `up_req`, `dn_ack`, `occupancy` go to 0 immediately; after release, the first delivered word is the first word pushed after reset.
